// File: rtl/fp_normalize_pack_pkg.sv
// Shared types and constants for the FP add back end (normalize, round, pack).
// Package name float_struct is what the datapath modules import.
package float_struct;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      OK  = 2'b00,
      NAN = 2'b01,
      INF = 2'b10,
      NUL = 2'b11
   } states;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } float_point_num;

   // Captured adder result, before any analysis
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
      states       cls;
   } raw_t;

   // Adder result plus carry / leading-zero / zero detection
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
      states       cls;
      logic        carry;
      logic [4:0]  lzc;
      logic        zero;
   } det_t;

   // Normalized value; exp is 10-bit two's complement so underflow stays visible
   typedef struct packed {
      logic        sign;
      logic [9:0]  exp;
      logic [23:0] mant;
      logic        g;
      logic        r;
      logic        s;
      states       cls;
      logic        zero;
   } norm_t;

   function automatic float_point_num pack_fp(input logic s, input logic [7:0] e, input logic [22:0] f);
      float_point_num v;
      v.sign = s;
      v.exp  = e;
      v.frac = f;
      return v;
   endfunction

endpackage

// File: rtl/fp_normalize_pack_lzc.sv
// fp_lzc24: combinational leading-zero counter for a 24-bit mantissa.
// Returns 0..23 for the index of the first set bit from the top, 24 when the input is zero.
module fp_lzc24 (
   input  logic [23:0] din,
   output logic [4:0]  cnt
);

   logic [5:0] nib_nz;
   logic [1:0] nib_cnt [6];

   // Nibble 0 is the most significant nibble
   for (genvar gi = 0; gi < 6; gi++) begin : g_nib
      logic [3:0] nib;
      assign nib         = din[23 - 4*gi -: 4];
      assign nib_nz[gi]  = |nib;
      assign nib_cnt[gi] = nib[3] ? 2'd0 :
                           nib[2] ? 2'd1 :
                           nib[1] ? 2'd2 : 2'd3;
   end

   always_comb begin
      cnt = 5'd24;
      for (int i = 5; i >= 0; i--) begin
         if (nib_nz[i]) begin
            cnt = 5'(4 * i) + {3'b000, nib_cnt[i]};
         end
      end
   end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalize, round and pack the raw FP adder result into an IEEE-754 single.
// Define FP_PACK_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_normalize_pack
   import float_struct::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sign,
   input  logic [EXP_W-1:0]        exp,
   input  logic [FRAC_W+1:0]       mant,
   input  logic [2:0]              grs,
   input  logic [1:0]              in_state,
   input  logic                    arg_vld,
   output logic                    arg_rdy,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic [1:0]              state,
   output logic                    res_vld,
   input  logic                    res_rdy
);

`ifdef FP_PACK_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   logic        adv;
   logic        raw_vld_q, raw_vld_d;
   logic        det_vld_q, det_vld_d;
   logic        norm_vld_q, norm_vld_d;
   logic        res_vld_q, res_vld_d;
   raw_t        raw_q, raw_d;
   det_t        det_q, det_d;
   norm_t       norm_q, norm_d;
   logic [31:0] result_q, result_d;
   states       state_q, state_d;

   logic [4:0]  lzc;
   logic [25:0] shl;
   logic        inc;
   logic        rnd_c;
   logic [22:0] frac_rnd;
   logic [9:0]  exp_rnd;

   // Whole pipeline advances together; a held output freezes every stage
   assign adv     = ~res_vld_q | res_rdy;
   assign arg_rdy = adv;

   fp_lzc24 u_lzc (
      .din (raw_q.mant[23:0]),
      .cnt (lzc)
   );

   always_comb begin
      raw_vld_d = raw_vld_q;
      raw_d     = raw_q;
      if (adv) begin
         raw_vld_d = arg_vld;
         if (arg_vld) begin
            raw_d.sign = sign;
            raw_d.exp  = exp;
            raw_d.mant = mant;
            raw_d.grs  = grs;
            raw_d.cls  = states'(in_state);
         end
      end
   end

   always_comb begin
      det_vld_d = det_vld_q;
      det_d     = det_q;
      if (adv) begin
         det_vld_d = raw_vld_q;
         if (raw_vld_q) begin
            det_d.sign  = raw_q.sign;
            det_d.exp   = raw_q.exp;
            det_d.mant  = raw_q.mant;
            det_d.grs   = raw_q.grs;
            det_d.cls   = raw_q.cls;
            det_d.carry = raw_q.mant[24];
            det_d.lzc   = lzc;
            det_d.zero  = (raw_q.mant == 25'd0) && (raw_q.grs == 3'd0);
         end
      end
   end

   always_comb begin
      norm_vld_d = norm_vld_q;
      norm_d     = norm_q;
      // Guard and round ride along with the mantissa on a left shift
      shl        = {det_q.mant[23:0], det_q.grs[2:1]} << det_q.lzc;
      if (adv) begin
         norm_vld_d = det_vld_q;
         if (det_vld_q) begin
            norm_d.sign = det_q.sign;
            norm_d.cls  = det_q.cls;
            norm_d.zero = det_q.zero;
            if (det_q.carry) begin
               norm_d.exp  = {2'b00, det_q.exp} + 10'd1;
               norm_d.mant = det_q.mant[24:1];
               norm_d.g    = det_q.mant[0];
               norm_d.r    = det_q.grs[2];
               norm_d.s    = det_q.grs[1] | det_q.grs[0];
            end else begin
               norm_d.exp  = {2'b00, det_q.exp} - {5'b00000, det_q.lzc};
               norm_d.mant = shl[25:2];
               norm_d.g    = shl[1];
               norm_d.r    = shl[0];
               norm_d.s    = det_q.grs[0];
            end
         end
      end
   end

   // A fraction wrap with the hidden bit set is a carry out of bit 23: exponent bumps, fraction is 0
   always_comb begin
      inc               = ROUND_EN & norm_q.g & (norm_q.r | norm_q.s | norm_q.mant[0]);
      {rnd_c, frac_rnd} = {1'b0, norm_q.mant[22:0]} + {23'd0, inc};
      exp_rnd           = norm_q.exp + {9'd0, rnd_c & norm_q.mant[23]};
   end

   always_comb begin
      res_vld_d = res_vld_q;
      result_d  = result_q;
      state_d   = state_q;
      if (adv) begin
         res_vld_d = norm_vld_q;
         if (norm_vld_q) begin
            if (norm_q.cls == NAN) begin
               result_d = QNAN;
               state_d  = NAN;
            end else if (norm_q.cls == INF) begin
               result_d = pack_fp(norm_q.sign, 8'hFF, 23'h0);
               state_d  = INF;
            end else if (norm_q.zero || (norm_q.cls == NUL)) begin
               result_d = 32'h0000_0000;
               state_d  = NUL;
            end else if ($signed(norm_q.exp) <= $signed(10'd0)) begin
               result_d = pack_fp(norm_q.sign, 8'h00, 23'h0);
               state_d  = NUL;
            end else if ($signed(exp_rnd) >= $signed(10'(EXP_MAX))) begin
               result_d = pack_fp(norm_q.sign, 8'hFF, 23'h0);
               state_d  = INF;
            end else begin
               result_d = pack_fp(norm_q.sign, exp_rnd[7:0], frac_rnd);
               state_d  = OK;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         raw_vld_q  <= 1'b0;
         det_vld_q  <= 1'b0;
         norm_vld_q <= 1'b0;
         res_vld_q  <= 1'b0;
         raw_q      <= '0;
         det_q      <= '0;
         norm_q     <= '0;
         result_q   <= 32'h0000_0000;
         state_q    <= OK;
      end else begin
         raw_vld_q  <= raw_vld_d;
         det_vld_q  <= det_vld_d;
         norm_vld_q <= norm_vld_d;
         res_vld_q  <= res_vld_d;
         raw_q      <= raw_d;
         det_q      <= det_d;
         norm_q     <= norm_d;
         result_q   <= result_d;
         state_q    <= state_d;
      end
   end

   assign result  = result_q;
   assign state   = state_q;
   assign res_vld = res_vld_q;

endmodule
